// File: rtl/ppu_nt_pkg.sv
// Shared types and the logical-to-physical page mapping for the PPU nametable RAM.
package ppu_nt_pkg;

    typedef enum logic [2:0] {
        HORIZ       = 3'd0,
        VERT        = 3'd1,
        SINGLE_LO   = 3'd2,
        SINGLE_HI   = 3'd3,
        FOUR_SCREEN = 3'd4
    } mirror_mode_t;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } nt_state_t;

    // Physical page for a logical nametable page. Unknown modes (5-7) fall back
    // to vertical mirroring, as does four-screen when only two pages exist.
    function automatic logic [1:0] nt_map(input logic [2:0] mode,
                                          input logic [1:0] lp,
                                          input int         num_pages);
        logic [1:0] page;
        case (mode)
            HORIZ:       page = {1'b0, lp[1]};
            SINGLE_LO:   page = 2'b00;
            SINGLE_HI:   page = 2'b01;
            FOUR_SCREEN: page = (num_pages == 4) ? lp : {1'b0, lp[0]};
            default:     page = {1'b0, lp[0]};
        endcase
        return page;
    endfunction

endpackage

// File: rtl/ppu_nametable_ram_nt_dpram.sv
// Plain true-dual-port RAM with registered, read-first outputs. When both ports
// write the same word in one cycle, port A's data is the one that lands.
module nt_dpram #(
    parameter int DATA_W = 8,
    parameter int AW     = 11
) (
    input  logic              clk,
    input  logic              en_a,
    input  logic              we_a,
    input  logic [AW-1:0]     addr_a,
    input  logic [DATA_W-1:0] din_a,
    output logic [DATA_W-1:0] dout_a,
    input  logic              en_b,
    input  logic              we_b,
    input  logic [AW-1:0]     addr_b,
    input  logic [DATA_W-1:0] din_b,
    output logic [DATA_W-1:0] dout_b
);

    localparam int DEPTH = 1 << AW;

`ifdef SYNTH
    (* ram_style = "block" *) logic [DATA_W-1:0] mem [DEPTH];
`else
    logic [DATA_W-1:0] mem [DEPTH];
`endif

    logic [DATA_W-1:0] dout_a_reg;
    logic [DATA_W-1:0] dout_b_reg;

    // Both ports share one process so the array has a single driver; port A's
    // write is issued last and therefore wins a same-word conflict.
    always_ff @(posedge clk) begin
        if (en_b) begin
            dout_b_reg <= mem[addr_b];
            if (we_b) begin
                mem[addr_b] <= din_b;
            end
        end
        if (en_a) begin
            dout_a_reg <= mem[addr_a];
            if (we_a) begin
                mem[addr_a] <= din_a;
            end
        end
    end

    assign dout_a = dout_a_reg;
    assign dout_b = dout_b_reg;

endmodule

// File: rtl/ppu_nametable_ram.sv
// Mirrored dual-port nametable RAM: address mapping, post-reset clear
// sequencer, and same-word write collision arbitration around nt_dpram.
module ppu_nametable_ram
    import ppu_nt_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                PAGE_AW   = 10,
    parameter int                NUM_PAGES = 2,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clk_en,
    input  logic [2:0]         mirror_mode,
    input  logic [PAGE_AW+1:0] addr_a,
    input  logic               we_a,
    input  logic [DATA_W-1:0]  din_a,
    output logic [DATA_W-1:0]  dout_a,
    input  logic [PAGE_AW+1:0] addr_b,
    input  logic               we_b,
    input  logic [DATA_W-1:0]  din_b,
    output logic [DATA_W-1:0]  dout_b,
    output logic               ready,
    output logic               collision
);

    localparam int            PAGE_BITS = (NUM_PAGES == 4) ? 2 : 1;
    localparam int            AW        = PAGE_AW + PAGE_BITS;
    localparam int            DEPTH     = NUM_PAGES << PAGE_AW;
    localparam logic [AW-1:0] CNT_LAST  = AW'(DEPTH - 1);

    nt_state_t state_reg, state_next;
    logic [AW-1:0] cnt_reg;
    logic          collision_reg;
    logic          rd_valid_reg;

    logic                       access;
    logic [1:0][PAGE_AW+1:0]    addr_log;
    logic [1:0][AW-1:0]         phys;
    logic                       same_word;
    logic                       col_now;

    logic              ram_en_a, ram_we_a, ram_en_b, ram_we_b;
    logic [AW-1:0]     ram_addr_a;
    logic [DATA_W-1:0] ram_din_a;
    logic [DATA_W-1:0] ram_dout_a, ram_dout_b;

    assign access   = clk_en && (state_reg == READY);
    assign addr_log = {addr_b, addr_a};

    // Map each port's logical offset to {physical page, in-page offset}; the
    // cast drops the unused upper page bit when only two pages exist.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_map
            assign phys[gi] = AW'({nt_map(mirror_mode, addr_log[gi][PAGE_AW+1:PAGE_AW], NUM_PAGES),
                                   addr_log[gi][PAGE_AW-1:0]});
        end
    endgenerate

    assign same_word = (phys[0] == phys[1]);
    assign col_now   = access && we_a && we_b && same_word;

    // Next state: clear runs once through every word, then READY until reset.
    always_comb begin
        state_next = state_reg;
        if ((state_reg == CLEAR) && (cnt_reg == CNT_LAST)) begin
            state_next = READY;
        end
    end

    // RAM port steering: the clear sequencer borrows port A; port B's write is
    // dropped on a same-word collision so port A's data is stored.
    always_comb begin
        ram_en_a   = access;
        ram_we_a   = access && we_a;
        ram_addr_a = phys[0];
        ram_din_a  = din_a;
        ram_en_b   = access;
        ram_we_b   = access && we_b && !(we_a && same_word);
        if (state_reg == CLEAR) begin
            ram_en_a   = 1'b1;
            ram_we_a   = 1'b1;
            ram_addr_a = cnt_reg;
            ram_din_a  = CLEAR_VAL;
        end
    end

    // FSM state register and clear word counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= CLEAR;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == CLEAR) begin
                cnt_reg <= cnt_reg + AW'(1);
            end
        end
    end

    // Collision pulse and the flag that unmasks RAM read data after the first access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            collision_reg <= 1'b0;
            rd_valid_reg  <= 1'b0;
        end else begin
            collision_reg <= col_now;
            if (access) begin
                rd_valid_reg <= 1'b1;
            end
        end
    end

    nt_dpram #(
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_ram (
        .clk    (clk),
        .en_a   (ram_en_a),
        .we_a   (ram_we_a),
        .addr_a (ram_addr_a),
        .din_a  (ram_din_a),
        .dout_a (ram_dout_a),
        .en_b   (ram_en_b),
        .we_b   (ram_we_b),
        .addr_b (phys[1]),
        .din_b  (din_b),
        .dout_b (ram_dout_b)
    );

    // Until a real access has happened the RAM output registers hold clear-time
    // data, so present zero instead.
    assign dout_a    = rd_valid_reg ? ram_dout_a : '0;
    assign dout_b    = rd_valid_reg ? ram_dout_b : '0;
    assign ready     = (state_reg == READY);
    assign collision = collision_reg;

endmodule

// File: tb/tb_ppu_nametable_ram.sv
// Self-checking bench: two DUTs (2 and 4 pages) share stimulus; a table of
// hand-derived vectors, corner sequences and random traffic against an array model.
module tb_ppu_nametable_ram;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_en;
    logic [2:0]  mirror_mode;
    logic [11:0] addr_a, addr_b;
    logic        we_a, we_b;
    logic [7:0]  din_a, din_b;

    logic [7:0]  dout_a2, dout_b2, dout_a4, dout_b4;
    logic        ready2, ready4, col2, col4;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [7:0] m2 [2048];
    logic [7:0] m4 [4096];
    logic [7:0] ea2, eb2, ea4, eb4;
    logic       ec2, ec4;

    always #5 clk = ~clk;

    ppu_nametable_ram #(.DATA_W(8), .PAGE_AW(10), .NUM_PAGES(2), .CLEAR_VAL(8'h00)) dut2 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .mirror_mode(mirror_mode),
        .addr_a(addr_a), .we_a(we_a), .din_a(din_a), .dout_a(dout_a2),
        .addr_b(addr_b), .we_b(we_b), .din_b(din_b), .dout_b(dout_b2),
        .ready(ready2), .collision(col2)
    );

    ppu_nametable_ram #(.DATA_W(8), .PAGE_AW(10), .NUM_PAGES(4), .CLEAR_VAL(8'h00)) dut4 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .mirror_mode(mirror_mode),
        .addr_a(addr_a), .we_a(we_a), .din_a(din_a), .dout_a(dout_a4),
        .addr_b(addr_b), .we_b(we_b), .din_b(din_b), .dout_b(dout_b4),
        .ready(ready4), .collision(col4)
    );

    typedef struct {
        logic [2:0]  mode;
        logic        wa;
        logic [11:0] aa;
        logic [7:0]  da;
        logic        wb;
        logic [11:0] ab;
        logic [7:0]  db;
        logic [7:0]  xa2, xb2, xa4, xb4;
        logic        xc;
    } vec_t;

    vec_t tbl [12];

    // Physical word index from the mirroring rules, in plain arithmetic.
    function automatic int phys(input int mode, input int addr, input int np);
        int lp   = addr / 1024;
        int off  = addr % 1024;
        int page;
        case (mode)
            0:       page = lp / 2;
            2:       page = 0;
            3:       page = 1;
            4:       page = (np == 4) ? lp : lp % 2;
            default: page = lp % 2;
        endcase
        return page * 1024 + off;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 2048; i++) m2[i] = 8'h00;
        for (int i = 0; i < 4096; i++) m4[i] = 8'h00;
        ea2 = 0; eb2 = 0; ea4 = 0; eb4 = 0; ec2 = 0; ec4 = 0;
    endtask

    // One clock of stimulus; the model is advanced with read-first, A-wins rules.
    task automatic step(input logic en, input logic [2:0] mode,
                        input logic wa, input logic [11:0] aa, input logic [7:0] da,
                        input logic wb, input logic [11:0] ab, input logic [7:0] db,
                        input bit quiet);
        int pa, pb;
        @(negedge clk);
        clk_en = en; mirror_mode = mode;
        we_a = wa; addr_a = aa; din_a = da;
        we_b = wb; addr_b = ab; din_b = db;
        @(posedge clk);
        #1;
        if (en) begin
            pa = phys(mode, aa, 2); pb = phys(mode, ab, 2);
            ea2 = m2[pa]; eb2 = m2[pb]; ec2 = wa && wb && (pa == pb);
            if (wb) m2[pb] = db;
            if (wa) m2[pa] = da;
            pa = phys(mode, aa, 4); pb = phys(mode, ab, 4);
            ea4 = m4[pa]; eb4 = m4[pb]; ec4 = wa && wb && (pa == pb);
            if (wb) m4[pb] = db;
            if (wa) m4[pa] = da;
        end else begin
            ec2 = 0; ec4 = 0;
        end
        if (!quiet)
            $display("txn en=%0d mode=%0d A:w%0d %03h %02h B:w%0d %03h %02h -> p2 %02h %02h c%0d | p4 %02h %02h c%0d",
                     en, mode, wa, aa, da, wb, ab, db, dout_a2, dout_b2, col2, dout_a4, dout_b4, col4);
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".p2_dout_a"}, dout_a2, ea2);
        chk({tag, ".p2_dout_b"}, dout_b2, eb2);
        chk({tag, ".p2_coll"},   col2,    ec2);
        chk({tag, ".p4_dout_a"}, dout_a4, ea4);
        chk({tag, ".p4_dout_b"}, dout_b4, eb4);
        chk({tag, ".p4_coll"},   col4,    ec4);
    endtask

    // Count clocks from reset release until each DUT reports ready; writes are
    // attempted early in the clear and must not be stored.
    task automatic wait_ready(input string tag);
        int c2 = 0;
        int c4 = 0;
        clk_en = 1; mirror_mode = 3'd1;
        we_a = 1; addr_a = 12'h010; din_a = 8'hFF;
        we_b = 1; addr_b = 12'h000; din_b = 8'hEE;
        for (int c = 1; c <= 5000; c++) begin
            @(posedge clk);
            #1;
            if (c2 == 0 && ready2) c2 = c;
            if (c4 == 0 && ready4) c4 = c;
            if (c == 100) begin
                chk({tag, ".clear_dout_a2"}, dout_a2, 0);
                chk({tag, ".clear_dout_b4"}, dout_b4, 0);
                chk({tag, ".clear_coll2"},   col2,    0);
                clk_en = 0; we_a = 0; we_b = 0;
            end
            if (c2 != 0 && c4 != 0) break;
        end
        chk({tag, ".p2_ready_clks"}, c2, 2048);
        chk({tag, ".p4_ready_clks"}, c4, 4096);
        $display("txn %s ready after p2=%0d p4=%0d clk", tag, c2, c4);
        clear_model();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int bad;
        tbl[0]  = '{3'd1, 1'b1, 12'h000, 8'h5A, 1'b0, 12'h800, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[1]  = '{3'd1, 1'b0, 12'h000, 8'h00, 1'b0, 12'h800, 8'h00, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 1'b0};
        tbl[2]  = '{3'd0, 1'b1, 12'h000, 8'h3C, 1'b0, 12'h400, 8'h00, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 1'b0};
        tbl[3]  = '{3'd0, 1'b0, 12'h400, 8'h00, 1'b0, 12'h800, 8'h00, 8'h3C, 8'h00, 8'h3C, 8'h00, 1'b0};
        tbl[4]  = '{3'd4, 1'b1, 12'h000, 8'h11, 1'b1, 12'h400, 8'h22, 8'h3C, 8'h00, 8'h3C, 8'h00, 1'b0};
        tbl[5]  = '{3'd4, 1'b1, 12'h800, 8'h33, 1'b1, 12'hC00, 8'h44, 8'h11, 8'h22, 8'h00, 8'h00, 1'b0};
        tbl[6]  = '{3'd4, 1'b0, 12'h000, 8'h00, 1'b0, 12'h400, 8'h00, 8'h33, 8'h44, 8'h11, 8'h22, 1'b0};
        tbl[7]  = '{3'd4, 1'b0, 12'h800, 8'h00, 1'b0, 12'hC00, 8'h00, 8'h33, 8'h44, 8'h33, 8'h44, 1'b0};
        tbl[8]  = '{3'd1, 1'b1, 12'h123, 8'hAA, 1'b1, 12'h123, 8'hBB, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1};
        tbl[9]  = '{3'd1, 1'b0, 12'h123, 8'h00, 1'b0, 12'h923, 8'h00, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 1'b0};
        tbl[10] = '{3'd1, 1'b1, 12'h010, 8'h77, 1'b0, 12'h010, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[11] = '{3'd1, 1'b0, 12'h010, 8'h00, 1'b0, 12'h010, 8'h00, 8'h77, 8'h77, 8'h77, 8'h77, 1'b0};

        rst_n = 0; clk_en = 0; mirror_mode = 3'd1;
        we_a = 0; addr_a = 0; din_a = 0; we_b = 0; addr_b = 0; din_b = 0;
        clear_model();

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.p2_dout_a", dout_a2, 0);
        chk("rst.p2_dout_b", dout_b2, 0);
        chk("rst.p2_ready",  ready2,  0);
        chk("rst.p2_coll",   col2,    0);
        chk("rst.p4_ready",  ready4,  0);
        chk("rst.p4_dout_a", dout_a4, 0);
        rst_n = 1;
        wait_ready("clear0");

        // every word reads back zero before any write
        bad = 0;
        for (int i = 0; i < 4096; i++) begin
            step(1'b1, 3'd4, 1'b0, 12'(i), 8'h00, 1'b0, 12'(4095 - i), 8'h00, 1'b1);
            if (dout_a2 !== 8'h00 || dout_b2 !== 8'h00 || dout_a4 !== 8'h00 || dout_b4 !== 8'h00) bad++;
        end
        chk("clear_sweep_nonzero_reads", bad, 0);
        $display("txn clear sweep of 4096 addresses, nonzero=%0d", bad);

        // directed vector table
        for (int i = 0; i < 12; i++) begin
            step(1'b1, tbl[i].mode, tbl[i].wa, tbl[i].aa, tbl[i].da,
                 tbl[i].wb, tbl[i].ab, tbl[i].db, 1'b0);
            chk($sformatf("vec%0d.p2_dout_a", i), dout_a2, tbl[i].xa2);
            chk($sformatf("vec%0d.p2_dout_b", i), dout_b2, tbl[i].xb2);
            chk($sformatf("vec%0d.p4_dout_a", i), dout_a4, tbl[i].xa4);
            chk($sformatf("vec%0d.p4_dout_b", i), dout_b4, tbl[i].xb4);
            chk($sformatf("vec%0d.coll2", i),     col2,    tbl[i].xc);
            chk($sformatf("vec%0d.coll4", i),     col4,    tbl[i].xc);
        end

        // clk_en low for 3 clk: outputs hold, attempted writes are not accesses
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 3'd1, 1'b1, 12'h010, 8'h99, 1'b1, 12'h010, 8'h98, 1'b0);
            chk($sformatf("hold%0d.p2_dout_a", i), dout_a2, 8'h77);
            chk($sformatf("hold%0d.p4_dout_b", i), dout_b4, 8'h77);
            chk($sformatf("hold%0d.coll2", i),     col2,    0);
        end
        step(1'b1, 3'd1, 1'b0, 12'h010, 8'h00, 1'b0, 12'h810, 8'h00, 1'b0);
        chk("hold_after.p2_dout_a", dout_a2, 8'h77);
        check_model("hold_after");

        // collision through mirroring alias lasts exactly one clk
        step(1'b1, 3'd1, 1'b1, 12'h200, 8'h01, 1'b1, 12'hA00, 8'h02, 1'b0);
        chk("alias_coll.p2", col2, 1);
        chk("alias_coll.p4", col4, 1);
        step(1'b0, 3'd1, 1'b0, 12'h200, 8'h00, 1'b0, 12'hA00, 8'h00, 1'b0);
        chk("alias_coll_end.p2", col2, 0);
        chk("alias_coll_end.p4", col4, 0);
        step(1'b1, 3'd1, 1'b0, 12'h200, 8'h00, 1'b0, 12'hA00, 8'h00, 1'b0);
        chk("alias_read.p2_dout_b", dout_b2, 8'h01);
        check_model("alias_read");

        // randomized traffic against the model, addresses clustered to provoke aliasing
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 12'($urandom_range(0, 3) * 1024 + $urandom_range(0, 3)), 8'($urandom),
                 1'($urandom_range(0, 1)), 12'($urandom_range(0, 3) * 1024 + $urandom_range(0, 3)), 8'($urandom),
                 1'b0);
            check_model($sformatf("rnd%0d", i));
        end

        // reset in the middle of the clear restarts it from word 0
        @(negedge clk);
        clk_en = 0; we_a = 0; we_b = 0;
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        repeat (500) @(posedge clk);
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("midrst.p2_ready",  ready2,  0);
        chk("midrst.p4_ready",  ready4,  0);
        chk("midrst.p2_dout_a", dout_a2, 0);
        @(negedge clk);
        rst_n = 1;
        wait_ready("clear_restart");
        step(1'b1, 3'd1, 1'b0, 12'h010, 8'h00, 1'b0, 12'h000, 8'h00, 1'b0);
        chk("post_clear.p2_0x010", dout_a2, 8'h00);
        check_model("post_clear0");
        step(1'b1, 3'd4, 1'b0, 12'h800, 8'h00, 1'b0, 12'h123, 8'h00, 1'b0);
        check_model("post_clear1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
